// File: rtl/alu_serial_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_ctrl_if
// Description : Handshake and data bundle for the bit-serial ALU controller.
//               master : requester side (drives Start/Select/Mode/A/B)
//               slave  : ALU side (drives Ready/Done/Result)
//   Start  - request to begin one operation
//   Select - 2-bit operation code, sampled on an accepted Start
//   Mode   - operation mode, sampled on an accepted Start
//   A, B   - WIDTH-bit operands, sampled on an accepted Start
//   Ready  - ALU idle, next Start will be accepted
//   Done   - one-cycle pulse, Result valid
//   Result - WIDTH-bit computed word
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic [1:0]       Select;
    logic             Mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ready;
    logic             Done;
    logic [WIDTH-1:0] Result;

    modport master (
        output Start, Select, Mode, A, B,
        input  Ready, Done, Result
    );

    modport slave (
        input  Start, Select, Mode, A, B,
        output Ready, Done, Result
    );
endinterface
`default_nettype wire

// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_ctrl
// Description : Bit-serial ALU. On an accepted Start the operands and opcode
//               are latched, then one 1-bit ALU evaluation per cycle fills
//               Result LSB first. Three-state FSM: IDLE -> RUN -> DONE.
//   Clk     - clock, rising edge
//   Reset_n - synchronous active-low reset
//   bus     - alu_serial_ctrl_if.slave (Start/Select/Mode/A/B in,
//             Ready/Done/Result out)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    alu_serial_ctrl_if.slave  bus
);

    localparam int               c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [1:0]       sel_q,    sel_d;
    logic             mode_q,   mode_d;
    logic [c_CW-1:0]  cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Single-bit ALU. In Mode=1 opcode 11 is (~a)^b, which is logically the
    // same as ~(a^b); both forms are kept to mirror the opcode table.
    function automatic logic alu_bit(input logic [1:0] sel, input logic mode,
                                     input logic a, input logic b);
        logic r;
        case (sel)
            2'b00:   r = a;
            2'b01:   r = ~a;
            2'b10:   r = a ^ b;
            default: r = mode ? ((~a) ^ b) : ~(a ^ b);
        endcase
        return r;
    endfunction

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q  <= c_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            c_IDLE: begin
                if (bus.Start) begin
                    state_d  = c_RUN;
                    a_d      = bus.A;
                    b_d      = bus.B;
                    sel_d    = bus.Select;
                    mode_d   = bus.Mode;
                    cnt_d    = '0;
                    result_d = '0;
                end
            end
            c_RUN: begin
                result_d[cnt_q] = alu_bit(sel_q, mode_q, a_q[cnt_q], b_q[cnt_q]);
                // Counter stops at the last bit, so it never wraps in RUN.
                if (cnt_q == c_LAST) begin
                    state_d = c_DONE;
                end else begin
                    cnt_d = cnt_q + c_CW'(1);
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // Outputs decode straight from registered state, so they only move on Clk.
    always_comb begin
        bus.Ready  = (state_q == c_IDLE);
        bus.Done   = (state_q == c_DONE);
        bus.Result = result_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_serial_ctrl
// Description : Self-checking bench for alu_serial_ctrl (WIDTH=8). Directed
//               table vectors, multi-cycle corner sequences and random
//               operations against a word-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_ctrl;

    logic Clk = 1'b0;
    logic Reset_n;
    int   total = 0;
    int   bad   = 0;

    always #5 Clk = ~Clk;

    alu_serial_ctrl_if #(.WIDTH(8)) bus ();

    alu_serial_ctrl #(.WIDTH(8)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [1:0] sel;
        logic       mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    // Word-level reference: each opcode applied to whole operands at once.
    function automatic logic [7:0] model(input logic [1:0] s, input logic m,
                                         input logic [7:0] a, input logic [7:0] b);
        case (s)
            2'd0:    return a;
            2'd1:    return ~a;
            2'd2:    return a ^ b;
            default: return m ? ((~a) ^ b) : ~(a ^ b);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. Returns at a negedge, idle again.
    task automatic run_op(input logic [1:0] s, input logic m, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp,
                          input bit disturb, input string name);
        int lat;
        int rlow;
        int extra;
        check({name, " ready before"}, 32'(bus.Ready), 32'd1);
        bus.Select = s;
        bus.Mode   = m;
        bus.A      = a;
        bus.B      = b;
        bus.Start  = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        lat  = 0;
        rlow = 0;
        while (!bus.Done && lat < 50) begin
            if (!bus.Ready) rlow++;
            if (disturb && lat == 3) begin
                bus.Start  = 1'b1;
                bus.A      = 8'hFF;
                bus.B      = ~b;
                bus.Select = ~s;
                bus.Mode   = ~m;
            end
            if (disturb && lat == 4) bus.Start = 1'b0;
            @(negedge Clk);
            lat++;
        end
        if (!bus.Ready) rlow++;
        check({name, " latency"},   32'(lat),        32'd8);
        check({name, " ready low"}, 32'(rlow),       32'd9);
        check({name, " result"},    32'(bus.Result), 32'(exp));
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            bus.A = 8'($urandom);
            bus.B = 8'($urandom);
            @(negedge Clk);
            if (bus.Done) extra++;
        end
        check({name, " extra done"}, 32'(extra),      32'd0);
        check({name, " ready after"}, 32'(bus.Ready), 32'd1);
        check({name, " hold"},       32'(bus.Result), 32'(exp));
    endtask

    initial begin : main
        int   cnt;
        int   idx;
        int   last;
        int   cyc;
        vec_t ops [3];
        logic [1:0] rs;
        logic       rm;
        logic [7:0] ra, rb;

        vecs[0] = '{2'b10, 1'b0, 8'hA5, 8'h0F, 8'hAA};
        vecs[1] = '{2'b01, 1'b0, 8'h3C, 8'h77, 8'hC3};
        vecs[2] = '{2'b00, 1'b0, 8'h5A, 8'h81, 8'h5A};
        vecs[3] = '{2'b11, 1'b0, 8'hF0, 8'hCC, 8'hC3};
        vecs[4] = '{2'b11, 1'b1, 8'hF0, 8'hCC, 8'hC3};
        vecs[5] = '{2'b11, 1'b1, 8'h00, 8'h0F, 8'hF0};
        vecs[6] = '{2'b10, 1'b1, 8'hA5, 8'h0F, 8'hAA};
        vecs[7] = '{2'b01, 1'b1, 8'h00, 8'h55, 8'hFF};

        Reset_n    = 1'b0;
        bus.Start  = 1'b0;
        bus.Select = 2'b00;
        bus.Mode   = 1'b0;
        bus.A      = 8'h00;
        bus.B      = 8'h00;
        repeat (3) @(negedge Clk);
        check("reset ready",  32'(bus.Ready),  32'd1);
        check("reset done",   32'(bus.Done),   32'd0);
        check("reset result", 32'(bus.Result), 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);

        foreach (vecs[i])
            run_op(vecs[i].sel, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp,
                   1'b0, $sformatf("vec%0d", i));

        // Start re-pulsed and operands changed mid-run must be ignored.
        run_op(2'b10, 1'b0, 8'hA5, 8'h0F, 8'hAA, 1'b1, "disturb");

        // Reset during RUN cycle 4 aborts the operation without a Done.
        bus.Select = 2'b10; bus.Mode = 1'b0; bus.A = 8'hA5; bus.B = 8'h0F;
        bus.Start  = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (3) @(negedge Clk);
        check("abort running ready", 32'(bus.Ready), 32'd0);
        Reset_n = 1'b0;
        @(negedge Clk);
        check("abort result", 32'(bus.Result), 32'd0);
        check("abort ready",  32'(bus.Ready),  32'd1);
        check("abort done",   32'(bus.Done),   32'd0);
        Reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge Clk);
            if (bus.Done) cnt++;
        end
        check("abort no done", 32'(cnt), 32'd0);
        run_op(2'b10, 1'b0, 8'hA5, 8'h0F, 8'hAA, 1'b0, "after abort");

        // Start held high: back-to-back operations every WIDTH+2 cycles.
        for (int i = 0; i < 3; i++) begin
            ops[i].sel  = 2'($urandom);
            ops[i].mode = 1'($urandom);
            ops[i].a    = 8'($urandom);
            ops[i].b    = 8'($urandom);
            ops[i].exp  = model(ops[i].sel, ops[i].mode, ops[i].a, ops[i].b);
        end
        bus.Select = ops[0].sel; bus.Mode = ops[0].mode;
        bus.A = ops[0].a; bus.B = ops[0].b;
        bus.Start = 1'b1;
        idx = 0; last = 0; cyc = 0;
        while (idx < 3 && cyc < 60) begin
            @(negedge Clk);
            cyc++;
            if (bus.Done) begin
                check($sformatf("held result%0d", idx), 32'(bus.Result), 32'(ops[idx].exp));
                if (idx > 0) check($sformatf("held spacing%0d", idx), 32'(cyc - last), 32'd10);
                last = cyc;
                idx++;
                if (idx < 3) begin
                    bus.Select = ops[idx].sel; bus.Mode = ops[idx].mode;
                    bus.A = ops[idx].a; bus.B = ops[idx].b;
                end else begin
                    bus.Start = 1'b0;
                end
            end
        end
        bus.Start = 1'b0;
        check("held count", 32'(idx), 32'd3);
        @(negedge Clk);

        // Random operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            rs = 2'($urandom);
            rm = 1'($urandom);
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(rs, rm, ra, rb, model(rs, rm, ra, rb), 1'($urandom_range(0, 1)),
                   $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-004 The block SHALL have port Start, input, 1 bit: request to begin one operation.
REQ-005 The block SHALL have port Select, input, 2 bits: operation code, sampled on an accepted Start.
REQ-006 The block SHALL have port Mode, input, 1 bit: operation mode, sampled on an accepted Start.
REQ-007 The block SHALL have port A, input, WIDTH bits: operand A, sampled on an accepted Start.
REQ-008 The block SHALL have port B, input, WIDTH bits: operand B, sampled on an accepted Start.
REQ-009 The block SHALL have port Ready, output, 1 bit: high when the block is in IDLE and will accept Start.
REQ-010 The block SHALL have port Done, output, 1 bit: one-cycle pulse marking Result valid.
REQ-011 The block SHALL have port Result, output, WIDTH bits: the computed word.

Function
REQ-012 The block SHALL compute Result bit-serially, using one 1-bit ALU evaluation per cycle, LSB first.
REQ-013 The per-bit function SHALL be as follows.
- Mode=0: 00 -> a; 01 -> ~a; 10 -> a^b; 11 -> ~(a^b).
- Mode=1: 00 -> a; 01 -> ~a; 10 -> a^b; 11 -> (~a)^b.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE -> RUN SHALL occur at the edge where Start=1 is sampled in IDLE (the accept edge); at that edge:
- A, B, Select and Mode are latched;
- the bit counter is cleared to 0;
- Result is cleared to 0.
REQ-016 In RUN, each edge SHALL write ALU(latched op, A_l[cnt], B_l[cnt]) into Result[cnt] and increment cnt.
REQ-017 RUN -> DONE SHALL occur at the edge that writes bit WIDTH-1, i.e. WIDTH edges after the accept edge.
REQ-018 DONE -> IDLE SHALL occur unconditionally on the next edge.
REQ-019 Done SHALL be 1 only while in DONE, which is exactly one cycle per operation.
REQ-020 Ready SHALL be 1 only while in IDLE.
REQ-021 Start SHALL be ignored in RUN and DONE; no latching takes place and no queuing of the request.
REQ-022 Changes on A, B, Select or Mode after the accept edge SHALL NOT affect the operation in progress.
REQ-023 Result SHALL hold its final value from DONE until the next accept edge.
REQ-024 Start held high continuously SHALL start a new operation at every IDLE cycle, giving a throughput of one result per WIDTH+2 cycles.
REQ-025 The bit counter SHALL be wide enough for WIDTH-1 and SHALL never wrap inside RUN.
REQ-026 Unused or illegal FSM encodings SHALL return to IDLE on the next edge.

Reset
REQ-027 When Reset_n=0 is sampled, the block SHALL set:
- state IDLE;
- Ready=1 on the following cycle;
- Done=0;
- Result=0;
- counter and latched operands = 0.
REQ-028 Reset SHALL take priority over Start and abort any RUN or DONE in progress, with no Done pulse for the aborted operation.
REQ-029 Outputs SHALL NOT change asynchronously on a Reset_n edge.

Verification
REQ-030 The bench SHALL cover the following directed scenarios, all with WIDTH=8.
- (a) Mode=0, Select=10, A=8'hA5, B=8'h0F, Start pulse -> Done exactly 8 cycles after the accept edge, Result=8'hAA, Ready low for 9 cycles.
- (b) Select=01, A=8'h3C -> Result=8'hC3; Select=00, A=8'h5A -> Result=8'h5A.
- (c) Select=11, A=8'hF0, B=8'hCC: Mode=0 -> 8'hC3; Mode=1 -> 8'hC3. Also Mode=1, Select=11, A=8'h00, B=8'h0F -> 8'hF0.
- (d) Start re-pulsed and A changed to 8'hFF mid-RUN of (a) -> ignored; Result=8'hAA; single Done.
- (e) Reset_n=0 for one cycle at RUN cycle 4 -> next cycle Result=0, Ready=1, Done never pulses; a fresh Start then completes normally.
- (f) Start held high for 3 operations -> Done pulses spaced 10 cycles apart, each Result correct.
